instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/riscv_pkg.sv | 11 +
 rtl/fetch_fifo.sv | 34 +++
 rtl/instr_fetch.sv | 90 +++++++++
 tb/tb_instr_fetch.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch-stage widths, buffer entry layout and FSM states
package riscv_pkg;
    localparam int DEFAULT_PC_WIDTH    = 32;
    localparam int DEFAULT_INSTR_WIDTH = 32;
    typedef struct packed {
        logic [DEFAULT_PC_WIDTH-1:0]    pc;
        logic [DEFAULT_INSTR_WIDTH-1:0] instr;
        logic                           err;
    } fetch_entry_t;
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous power-of-two FIFO with clear; simultaneous push/pop legal even when full
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + AW'(push);
            rptr  <= rptr + AW'(pop);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= din;
    end
    assign dout = mem[rptr];
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: reserving fetch unit with tag queue, flush drain and optional INSTR_FETCH_MISALIGN_CHECK_EN error flag
module instr_fetch
    import riscv_pkg::*;
#(
    parameter int PC_WIDTH    = DEFAULT_PC_WIDTH,
    parameter int INSTR_WIDTH = DEFAULT_INSTR_WIDTH,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PC_WIDTH-1:0]    pc_in,
    output logic                   pc_advance,
    input  logic                   flush,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_gnt,
    input  logic                   imem_rvalid,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]    instr_pc,
    output logic                   instr_err
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    fetch_state_t        state, state_next;
    logic [CW-1:0]       outstanding, discard_cnt, discard_next, fifo_count, tag_count;
    logic [PC_WIDTH-1:0] tag_pc;
    logic                rsp, keep, tag_pop;
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
    localparam int DW = PC_WIDTH + INSTR_WIDTH + 1;
    logic [DW-1:0] push_din, head;
    assign push_din  = {tag_pc, imem_rdata, tag_pc[1:0] != 2'b00};
    assign instr_err = instr_valid && head[0];
`else
    localparam int DW = PC_WIDTH + INSTR_WIDTH;
    logic [DW-1:0] push_din, head;
    assign push_din  = {tag_pc, imem_rdata};
    assign instr_err = 1'b0;
`endif
    // responses with nothing outstanding are strays (e.g. from before reset) and are ignored
    assign rsp        = imem_rvalid && outstanding != '0;
    assign keep       = rsp && state == FETCH && !flush;
    assign tag_pop    = keep && tag_count != '0;
    assign imem_addr  = pc_in;
    // reserve a buffer slot for every in-flight request so the FIFO can never overflow
    assign imem_req   = !rst && !flush && state == FETCH &&
                        ({1'b0, fifo_count} + {1'b0, outstanding} < (CW+1)'(FIFO_DEPTH));
    assign pc_advance = imem_req && imem_gnt;
    assign instr_valid = !rst && fifo_count != '0 && state != DRAIN;
    assign instr_pc    = instr_valid ? head[DW-1 -: PC_WIDTH] : '0;
    assign instr       = instr_valid ? head[DW-PC_WIDTH-1 -: INSTR_WIDTH] : '0;
    always_comb begin
        discard_next = discard_cnt;
        if (flush) discard_next = outstanding - CW'(rsp);
        else if (state == DRAIN && rsp) discard_next = discard_cnt - CW'(1);
        state_next = state == IDLE ? FETCH : (discard_next != '0 ? DRAIN : FETCH);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            outstanding <= '0;
            discard_cnt <= '0;
        end else begin
            state       <= state_next;
            outstanding <= outstanding + CW'(pc_advance) - CW'(rsp);
            discard_cnt <= discard_next;
        end
    end
    fetch_fifo #(.WIDTH(PC_WIDTH), .DEPTH(FIFO_DEPTH)) tag_q (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (pc_advance),
        .pop   (tag_pop),
        .din   (pc_in),
        .dout  (tag_pc),
        .count (tag_count)
    );
    fetch_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) data_q (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (keep),
        .pop   (instr_valid && instr_ready),
        .din   (push_din),
        .dout  (head),
        .count (fifo_count)
    );
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard + vector-table bench for instr_fetch, honouring INSTR_FETCH_MISALIGN_CHECK_EN
module tb_instr_fetch;
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        err;
    } exp_t;
    typedef struct {
        logic [31:0] pc;
        logic        mis;
    } vec_t;

    logic        clk, rst, flush, imem_gnt, imem_rvalid, instr_ready;
    logic [31:0] pc_in, imem_rdata;
    logic        pc_advance, imem_req, instr_valid, instr_err;
    logic [31:0] imem_addr, instr, instr_pc;

    int          n_cmp = 0, n_err = 0, ngrant = 0;
    bit          auto_mem = 1, seq_en = 1;
    logic [31:0] seq_pc = 0;
    logic [31:0] pend[$];
    exp_t        exp_q[$];
    vec_t        vecs[6];

    instr_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .pc_in       (pc_in),
        .pc_advance  (pc_advance),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_err   (instr_err)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rd(input logic [31:0] a);
        return (a * 32'd3) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // one clock: sample handshakes before the edge, model memory and PC register after it
    task automatic tick();
        logic        g, adv;
        logic [31:0] a;
        exp_t        e;
        g   = imem_req && imem_gnt;
        adv = pc_advance;
        a   = pc_in;
        if (g) chk("imem_addr", imem_addr, a);
        if (instr_valid && instr_ready) begin
            if (exp_q.size() == 0) chk("unexpected_pop", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("pop_pc", instr_pc, e.pc);
                chk("pop_instr", instr, e.ins);
                chk("pop_err", instr_err, e.err);
            end
            if (seq_en) begin
                chk("seq_pc", instr_pc, seq_pc);
                seq_pc += 4;
            end
        end
        @(posedge clk);
        #1;
        if (g) begin
            pend.push_back(a);
            exp_q.push_back('{a, rd(a), MIS_EN && a[1:0] != 2'b00});
            ngrant++;
        end
        if (adv) pc_in = a + 4;
        if (auto_mem) begin
            if (pend.size() != 0) begin
                imem_rvalid = 1;
                imem_rdata  = rd(pend.pop_front());
            end else imem_rvalid = 0;
        end
        #1;
    endtask

    initial begin
        vecs = '{'{32'h0000_0100, 0}, '{32'h0000_0102, 1}, '{32'h0000_0203, 1},
                 '{32'hFFFF_FFFC, 0}, '{32'h0000_0001, 1}, '{32'h0000_0008, 0}};
        rst = 1; flush = 0; imem_gnt = 1; imem_rvalid = 0; imem_rdata = 0;
        instr_ready = 0; pc_in = 0;
        repeat (3) begin
            tick();
            chk("rst_req", imem_req, 0);
            chk("rst_valid", instr_valid, 0);
        end
        chk("rst_adv", pc_advance, 0);
        chk("rst_err", instr_err, 0);
        chk("rst_pc", instr_pc, 0);
        chk("rst_instr", instr, 0);
        rst = 0;
        #1;
        chk("idle_req", imem_req, 0);
        tick();
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, 0);
        chk("first_adv", pc_advance, 1);
        // backpressure: two entries buffered with decode stalled
        repeat (3) tick();
        chk("bp_valid", instr_valid, 1);
        chk("bp_req", imem_req, 0);
        chk("bp_adv", pc_advance, 0);
        chk("bp_head", instr_pc, 0);
        instr_ready = 1;
        tick();
        instr_ready = 0;
        ngrant = 0;
        repeat (5) tick();
        chk("bp_one_req", ngrant, 1);
        chk("bp_head2", instr_pc, 4);
        // streaming with decode always ready; pushes and pops overlap on an occupied buffer
        instr_ready = 1;
        repeat (12) tick();
        imem_gnt = 0;
        repeat (4) tick();
        chk("drained", instr_valid, 0);
        // flush with two requests outstanding
        seq_en = 0; auto_mem = 0; imem_rvalid = 0; imem_gnt = 1;
        #1;
        repeat (2) tick();
        chk("reserve_req", imem_req, 0);
        flush = 1; pc_in = 32'h100;
        #1;
        chk("flush_req", imem_req, 0);
        tick();
        flush = 0;
        pend.delete();
        exp_q.delete();
        imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("drain_valid1", instr_valid, 0);
        chk("drain_req", imem_req, 0);
        tick();
        imem_rvalid = 0;
        #1;
        chk("drain_valid2", instr_valid, 0);
        chk("post_flush_req", imem_req, 1);
        chk("post_flush_addr", imem_addr, 32'h100);
        // vector table: single fetches at assorted (mis)aligned PCs
        auto_mem = 1;
        foreach (vecs[i]) begin
            imem_gnt = 0; instr_ready = 1;
            repeat (3) tick();
            instr_ready = 0; pc_in = vecs[i].pc; imem_gnt = 1;
            #1;
            chk("vec_req", imem_req, 1);
            chk("vec_addr", imem_addr, vecs[i].pc);
            tick();
            imem_gnt = 0;
            tick();
            chk("vec_valid", instr_valid, 1);
            chk("vec_pc", instr_pc, vecs[i].pc);
            chk("vec_err", instr_err, MIS_EN && vecs[i].mis);
            instr_ready = 1;
        end
        repeat (2) tick();
        // reset mid-flight: the late response must be ignored
        auto_mem = 0; imem_gnt = 1; pc_in = 32'h40;
        #1;
        tick();
        imem_gnt = 0; rst = 1;
        tick();
        rst = 0;
        pend.delete();
        exp_q.delete();
        imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("rstmid_req", imem_req, 0);
        tick();
        imem_rvalid = 0;
        tick();
        chk("rstmid_valid", instr_valid, 0);
        chk("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
